// File: rtl/spi_device_interface.sv
// ============================================================================
// Module   : spi_device_interface
// Purpose  : SPI mode 0 (CPOL=0, CPHA=0) device / responder. Oversamples the
//            raw SPI pins in the fabric clock domain, deserialises MOSI into
//            bytes and serialises MISO from a one-byte holding register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES       flops per pin synchroniser (>= 2)
//   DEFAULT_TX_BYTE   byte shifted out when the holding register is empty
// Ports
//   clk, rst_n        fabric clock (>= 8x sck), asynchronous active-low reset
//   spi_sck/cs_n/mosi raw SPI inputs
//   spi_miso          device->host data, MSB first
//   spi_miso_oe       pad output enable (1 while selected)
//   rx_data_valid     one-cycle strobe, rx_data/rx_first valid
//   rx_data, rx_first received byte, first-byte-of-frame qualifier
//   tx_data_valid     one-cycle write strobe for the holding register
//   tx_data           byte to write into the holding register
//   tx_data_needed    one-cycle strobe: holding register was consumed
//   tx_underflow      one-cycle strobe: load point hit an empty register
//   frame_done        one-cycle strobe at end of frame (stats build)
//   frame_byte_count  whole bytes received in the last frame (stats build)
// Build option
//   SPI_DEVICE_FRAME_STATS_EN : builds the per-frame byte counter; otherwise
//   frame_done and frame_byte_count are tied to 0.
// ============================================================================
`default_nettype none

module spi_device_interface #(
    parameter int          SYNC_STAGES     = 2,
    parameter logic [7:0]  DEFAULT_TX_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        rx_data_valid,
    output logic [7:0]  rx_data,
    output logic        rx_first,
    input  logic        tx_data_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_data_needed,
    output logic        tx_underflow,
    output logic        frame_done,
    output logic [15:0] frame_byte_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one delay flop each for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic cs_s;
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];

    // Registered event pulses. sck edges are masked while cs_n is high,
    // which also makes a cs_n rise win over a coincident sck edge.
    logic ev_sck_rise;
    logic ev_sck_fall;
    logic ev_cs_fall;
    logic ev_cs_rise;
    logic ev_mosi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_sck_rise <= 1'b0;
            ev_sck_fall <= 1'b0;
            ev_cs_fall  <= 1'b0;
            ev_cs_rise  <= 1'b0;
            ev_mosi     <= 1'b0;
        end else begin
            ev_sck_rise <=  sck_s & ~sck_d & ~cs_s;
            ev_sck_fall <= ~sck_s &  sck_d & ~cs_s;
            ev_cs_fall  <= ~cs_s  &  cs_d;
            ev_cs_rise  <=  cs_s  & ~cs_d;
            ev_mosi     <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   load_point;
    logic   load_pending;   // 8th rise seen; the following fall loads a byte

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_point = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_cs_fall) begin
                    state_next = ST_ACTIVE;
                    load_point = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ev_cs_rise) begin
                    state_next = ST_IDLE;
                end else if (ev_sck_fall && load_pending) begin
                    load_point = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [7:0] tx_shift;
    logic [7:0] hold_data;
    logic       hold_full;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       first_byte;
    logic       byte_done;
    logic       byte_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift       <= 8'h00;
            hold_data      <= 8'h00;
            hold_full      <= 1'b0;
            rx_shift       <= 8'h00;
            bit_cnt        <= 3'd0;
            first_byte     <= 1'b0;
            load_pending   <= 1'b0;
            byte_done      <= 1'b0;
            byte_first     <= 1'b0;
            rx_data        <= 8'h00;
            rx_data_valid  <= 1'b0;
            rx_first       <= 1'b0;
            tx_data_needed <= 1'b0;
            tx_underflow   <= 1'b0;
        end else begin
            tx_data_needed <= 1'b0;
            tx_underflow   <= 1'b0;
            byte_done      <= 1'b0;

            // Output stage for a completed byte
            rx_data_valid <= byte_done;
            if (byte_done) begin
                rx_data  <= rx_shift;
                rx_first <= byte_first;
            end

            // Load takes the holding contents as they were before any
            // same-cycle write; the write below then re-marks it full.
            if (load_point) begin
                load_pending <= 1'b0;
                if (hold_full) begin
                    tx_shift       <= hold_data;
                    hold_full      <= 1'b0;
                    tx_data_needed <= 1'b1;
                end else begin
                    tx_shift     <= DEFAULT_TX_BYTE;
                    tx_underflow <= 1'b1;
                end
            end

            if (tx_data_valid) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (state == ST_IDLE) begin
                if (ev_cs_fall) begin
                    bit_cnt    <= 3'd0;
                    first_byte <= 1'b1;
                end
            end else if (ev_cs_rise) begin
                // Partial byte discarded; holding register untouched
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
                tx_shift     <= 8'h00;
            end else begin
                if (ev_sck_rise) begin
                    rx_shift <= {rx_shift[6:0], ev_mosi};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done    <= 1'b1;
                        byte_first   <= first_byte;
                        first_byte   <= 1'b0;
                        load_pending <= 1'b1;
                    end
                end
                if (ev_sck_fall && !load_pending) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso_oe = (state == ST_ACTIVE);
    assign spi_miso    = (state == ST_ACTIVE) & tx_shift[7];

    // ------------------------------------------------------------------
    // Optional per-frame statistics
    // ------------------------------------------------------------------
`ifdef SPI_DEVICE_FRAME_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt_next;

    // Saturating count including a strobe landing in the current cycle
    always_comb begin
        frame_cnt_next = frame_cnt;
        if (rx_data_valid && (frame_cnt != 16'hffff)) begin
            frame_cnt_next = frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt        <= 16'h0000;
            frame_done       <= 1'b0;
            frame_byte_count <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            if ((state == ST_IDLE) && ev_cs_fall) begin
                frame_cnt <= 16'h0000;
            end else begin
                frame_cnt <= frame_cnt_next;
            end
            if ((state == ST_ACTIVE) && ev_cs_rise) begin
                frame_done       <= 1'b1;
                frame_byte_count <= frame_cnt_next;
            end
        end
    end
`else
    assign frame_done       = 1'b0;
    assign frame_byte_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_device_interface.sv
// ============================================================================
// Module   : tb_spi_device_interface
// Purpose  : Self-checking bench for spi_device_interface. A host model drives
//            mode 0 frames at sck = clk/10; received bytes are checked through
//            an expected-byte queue and frame-level results against a table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_device_interface;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 5;
`ifdef SPI_DEVICE_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        rx_data_valid;
    logic [7:0]  rx_data;
    logic        rx_first;
    logic        tx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_needed;
    logic        tx_underflow;
    logic        frame_done;
    logic [15:0] frame_byte_count;

    spi_device_interface #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEFAULT_TX_BYTE (8'h00)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .spi_sck          (spi_sck),
        .spi_cs_n         (spi_cs_n),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .spi_miso_oe      (spi_miso_oe),
        .rx_data_valid    (rx_data_valid),
        .rx_data          (rx_data),
        .rx_first         (rx_first),
        .tx_data_valid    (tx_data_valid),
        .tx_data          (tx_data),
        .tx_data_needed   (tx_data_needed),
        .tx_underflow     (tx_underflow),
        .frame_done       (frame_done),
        .frame_byte_count (frame_byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         first;
        int         rise_cyc;
    } exp_t;

    typedef struct {
        bit          pre_en;
        logic [7:0]  pre;
        bit          sup_en;
        logic [7:0]  sup;
        int          n;
        logic [31:0] mosi;
        logic [31:0] miso;
        int          exp_need;
        int          exp_unf;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[4];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         need_cnt, unf_cnt, strobe_cnt, done_cnt;
    bit         sup_en = 1'b0;
    logic [7:0] sup_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step: samples DUT strobes, answers tx_data_needed when enabled
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tx_data_valid) tx_data_valid = 1'b0;
        if (tx_data_needed) begin
            need_cnt++;
            if (sup_en) begin
                tx_data       = sup_byte;
                tx_data_valid = 1'b1;
            end
        end
        if (tx_underflow) unf_cnt++;
        if (frame_done) done_cnt++;
        if (rx_data_valid) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected_strobe", {31'd0, rx_data_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("rx_first", {31'd0, rx_first}, {31'd0, e.first});
                check("rx_latency", cyc - e.rise_cyc, SYNC_STAGES + 3);
            end
        end
    endtask

    task automatic clear_counts();
        need_cnt   = 0;
        unf_cnt    = 0;
        strobe_cnt = 0;
        done_cnt   = 0;
    endtask

    // Full frame; the last sck fall coincides with the cs_n rise
    task automatic spi_frame(input int n, input logic [31:0] mosi_w, output logic [31:0] miso_w);
        logic [7:0] m;
        logic [7:0] rd;
        exp_t       e;
        miso_w   = 32'd0;
        spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int b = 0; b < n; b++) begin
            m = mosi_w[31-8*b -: 8];
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = m[i];
                repeat (HALF) tick();
                spi_sck = 1'b1;
                rd[i]   = spi_miso;
                if (i == 0) begin
                    e.data     = m;
                    e.first    = (b == 0);
                    e.rise_cyc = cyc;
                    exp_q.push_back(e);
                end
                repeat (HALF) tick();
                spi_sck = 1'b0;
                if (b == n - 1 && i == 0) spi_cs_n = 1'b1;
            end
            miso_w[31-8*b -: 8] = rd;
        end
        repeat (12) tick();
    endtask

    task automatic spi_partial(input int nbits);
        spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = 1'b1;
            repeat (HALF) tick();
            spi_sck = 1'b1;
            repeat (HALF) tick();
            spi_sck = 1'b0;
        end
        repeat (HALF) tick();
        spi_cs_n = 1'b1;
        repeat (12) tick();
    endtask

    logic [31:0] miso_got;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1, 32'h3C000000, 32'hA5000000, 1, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 2, 32'h01020000, 32'h00000000, 0, 2};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 8'h11, 3, 32'hC35AFF00, 32'hA5111100, 3, 0};
        // Holding register still carries 8'h11 from the previous frame
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 4, 32'h12345678, 32'h11000000, 1, 3};

        rst_n         = 1'b0;
        spi_sck       = 1'b0;
        spi_cs_n      = 1'b1;
        spi_mosi      = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        clear_counts();
        repeat (3) tick();
        check("reset_outputs",
              {1'b0, spi_miso, spi_miso_oe, rx_data_valid, rx_data, rx_first,
               tx_data_needed, tx_underflow, frame_done, frame_byte_count},
              32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_oe", {31'd0, spi_miso_oe}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            clear_counts();
            if (vecs[v].pre_en) begin
                tx_data       = vecs[v].pre;
                tx_data_valid = 1'b1;
                tick();
            end
            sup_en   = vecs[v].sup_en;
            sup_byte = vecs[v].sup;
            spi_frame(vecs[v].n, vecs[v].mosi, miso_got);
            sup_en = 1'b0;
            check($sformatf("v%0d_miso", v), miso_got, vecs[v].miso);
            check($sformatf("v%0d_needed", v), need_cnt, vecs[v].exp_need);
            check($sformatf("v%0d_underflow", v), unf_cnt, vecs[v].exp_unf);
            check($sformatf("v%0d_strobes", v), strobe_cnt, vecs[v].n);
            check($sformatf("v%0d_frame_done", v), done_cnt, STATS ? 1 : 0);
            check($sformatf("v%0d_byte_count", v), {16'd0, frame_byte_count},
                  STATS ? vecs[v].n : 0);
            check($sformatf("v%0d_oe_after", v), {31'd0, spi_miso_oe}, 32'd0);
        end

        // Aborted byte followed by a fresh frame
        clear_counts();
        spi_partial(5);
        check("partial_no_strobe", strobe_cnt, 0);
        check("partial_frame_done", done_cnt, STATS ? 1 : 0);
        check("partial_byte_count", {16'd0, frame_byte_count}, 32'd0);
        clear_counts();
        spi_frame(1, 32'hF0000000, miso_got);
        check("after_partial_strobes", strobe_cnt, 1);

        // Reset mid-frame with a full holding register
        clear_counts();
        spi_cs_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            repeat (HALF) tick();
            spi_sck = 1'b1;
            repeat (HALF) tick();
            spi_sck = 1'b0;
        end
        tx_data       = 8'h77;
        tx_data_valid = 1'b1;
        tick();
        check("pre_reset_oe", {31'd0, spi_miso_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {1'b0, spi_miso, spi_miso_oe, rx_data_valid, rx_data, rx_first,
               tx_data_needed, tx_underflow, frame_done, frame_byte_count},
              32'd0);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_oe", {31'd0, spi_miso_oe}, 32'd0);
        clear_counts();
        spi_frame(1, 32'h9A000000, miso_got);
        check("post_reset_miso", miso_got, 32'h00000000);
        check("post_reset_underflow", unf_cnt, 1);
        check("post_reset_needed", need_cnt, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
